ama_riscv_mmio: RTL and testbench
=================================

Name: ama_riscv_mmio

Overview:
Memory-mapped I/O slave beside the DMEM on the core's data port, selected by the core's address decode. Holds the tohost register that the bench polls for pass/fail. Provides 64-bit cycle and retired-instruction counters for comparison against bench perf stats. Provides a byte console FIFO drained through a valid/ready port.

Parameters:
CON_FIFO_DEPTH, 4, console FIFO entries; power of 2, minimum 2
CNT_W, 64, width of cycle/instret counters; fixed 64 for the HI/LO map

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
mmio_en  in  1  access strobe (load or store) to MMIO region
mmio_we  in  4  byte write enables; 0 with mmio_en = read
mmio_addr  in  6  word offset within MMIO region
mmio_wdata  in  32  store data
mmio_rdata  out  32  load data, valid cycle after mmio_en
inst_wb_nop_or_clear  in  1  WB slot is bubble/flushed; 0 = instruction retired this cycle
tohost  out  32  tohost register; bit0 = done, [31:1] = failing test number
con_data  out  8  console byte at FIFO head
con_valid  out  1  FIFO non-empty
con_ready  in  1  consumer accepts con_data when con_valid & con_ready

Behaviour:
- Reset (async, immediate): tohost=0, mmio_rdata=0, cycle=0, instret=0, hi_shadow=0, freeze=0, FIFO empty, con_valid=0, con_data=0, overflow=0.
- Register map (word offset):
  - 0x00 TOHOST, RW; byte-lane writes per mmio_we.
  - 0x01 CYCLE_LO, RO. 0x02 CYCLE_HI, RO.
  - 0x03 INSTRET_LO, RO. 0x04 INSTRET_HI, RO.
  - 0x05 CNT_CTRL, WO via lane 0. bit0 = clear both counters (self-clearing); bit1 = freeze (sticky level). Reads return {30'b0, freeze, 1'b0}.
  - 0x06 CON_TX, WO via lane 0; pushes wdata[7:0]. Reads return 0.
  - 0x07 CON_STATUS, RO except bit5. bit0 full, bit1 empty, bits[4:2] count (saturating at 7), bit5 overflow (write 1 on lane 0 clears it).
  - Other offsets: read 0, writes ignored.
- Read latency: exactly 1 cycle, matching DMEM sync read. mmio_rdata updates only on cycles with mmio_en & mmio_we==0, and holds otherwise.
- Counters:
  - cycle increments every cycle unless freeze=1.
  - instret increments on cycles with inst_wb_nop_or_clear==0, unless freeze=1.
  - Both wrap modulo 2^64 with no flag.
- HI/LO coherence:
  - A read of CYCLE_LO captures cycle[63:32] into cyc_hi_shadow in the same edge as the LO data. A CYCLE_HI read returns the shadow.
  - INSTRET uses its own shadow in the same way.
  - A HI read without a prior LO read returns the shadow as of the last LO read (0 after reset).
  - Read data reflects counter value before this cycle's increment.
- Clear vs increment: a CNT_CTRL clear write wins. Both counters read 0 on the following cycle, and the write cycle itself is not counted. Clear also zeroes both shadows.
- Console FIFO:
  - A pop occurs when con_valid & con_ready. con_data is the registered head, so no combinational path from con_ready.
  - A push to a FIFO full at cycle start with no concurrent pop is dropped and sets overflow.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push is not visible until the next cycle (no bypass).
  - Pointers wrap modulo CON_FIFO_DEPTH.
- TOHOST writes are never blocked. A write with bit0=1 holds until a further write or reset.
- rst asserted mid-operation: FIFO contents discarded, counters zeroed, in-flight read data lost.

Decomposition:
- Package ama_riscv_mmio_pkg holds:
  - Word-offset localparams (MMIO_TOHOST … MMIO_CON_STATUS).
  - CNT_CTRL and CON_STATUS bit-position constants.
  - TOHOST_PASS = 32'd1.
- Sub-module ama_riscv_fifo: parameterised DEPTH/WIDTH synchronous FIFO with push/pop/full/empty/count, async active-high reset. It is instantiated once for the console.
- Counter, shadow and decode logic stay in the top.

Test Plan:
- Reset release, run 10 cycles with inst_wb_nop_or_clear=0 every other cycle, read CYCLE_LO then INSTRET_LO -> 1 cycle later rdata = cycles elapsed minus 1 at read edge; instret = 5.
- Write TOHOST=0x0000_0001 with we=4'b1111 -> tohost=1 next cycle. Then byte-write we=4'b0010, wdata=0x0000_AB00 -> tohost=0x0000_AB01.
- Force cycle to 0x0000_0000_FFFF_FFFF via a clear plus run; read CYCLE_LO when LO=0xFFFF_FFFF, carry occurs, then read CYCLE_HI -> HI returns 0x0, not 0x1 (shadow coherence).
- Write CNT_CTRL=0x1 on the same cycle an instruction retires -> next-cycle reads of CYCLE_LO and INSTRET_LO (issued immediately) return 0.
- con_ready=0, push bytes 0x41..0x45 (5 pushes, depth 4) -> CON_STATUS = full=1, count=4, overflow=1. Set con_ready=1 -> con_data sequence 0x41,0x42,0x43,0x44, then con_valid=0. Write 0x20 to CON_STATUS -> overflow=0.
- FIFO full, con_ready=1, push 0x5A same cycle as pop -> count stays 4, no overflow, 0x5A emerges last. Assert rst mid-drain -> con_valid=0 immediately, tohost=0.

Source files
------------

// File: rtl/ama_riscv_mmio_pkg.sv
// Shared constants for the MMIO slave: word-offset map, control/status bit
// positions and the byte-lane merge helper.
package ama_riscv_mmio_pkg;

  localparam logic [5:0] MMIO_TOHOST     = 6'h00;
  localparam logic [5:0] MMIO_CYCLE_LO   = 6'h01;
  localparam logic [5:0] MMIO_CYCLE_HI   = 6'h02;
  localparam logic [5:0] MMIO_INSTRET_LO = 6'h03;
  localparam logic [5:0] MMIO_INSTRET_HI = 6'h04;
  localparam logic [5:0] MMIO_CNT_CTRL   = 6'h05;
  localparam logic [5:0] MMIO_CON_TX     = 6'h06;
  localparam logic [5:0] MMIO_CON_STATUS = 6'h07;

  localparam int CNT_CTRL_CLR = 0;
  localparam int CNT_CTRL_FRZ = 1;

  localparam int CON_ST_FULL    = 0;
  localparam int CON_ST_EMPTY   = 1;
  localparam int CON_ST_CNT_LSB = 2;
  localparam int CON_ST_OVF     = 5;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE
  } mmio_acc_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  we);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ama_riscv_mmio_if.sv
// Core data-port view of the MMIO region: strobe, lane enables, address,
// store data and the one-cycle-late load data.
interface ama_riscv_mmio_if;
  logic        mmio_en;
  logic [3:0]  mmio_we;
  logic [5:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  modport master (output mmio_en, mmio_we, mmio_addr, mmio_wdata,
                  input  mmio_rdata);
  modport slave  (input  mmio_en, mmio_we, mmio_addr, mmio_wdata,
                  output mmio_rdata);
endinterface

// File: rtl/ama_riscv_fifo.sv
// Small synchronous FIFO; head entry is read straight from the storage
// registers so the consumer's ready never reaches the data path.
module ama_riscv_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ama_riscv_mmio.sv
// MMIO slave next to DMEM: tohost, 64-bit cycle/instret counters with
// HI/LO shadow capture, and a byte console FIFO on a valid/ready port.
module ama_riscv_mmio
  import ama_riscv_mmio_pkg::*;
#(
  parameter int CON_FIFO_DEPTH = 4,
  parameter int CNT_W          = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ama_riscv_mmio_if.slave      mmio,
  input  logic                 inst_wb_nop_or_clear,
  output logic [31:0]          tohost,
  output logic [7:0]           con_data,
  output logic                 con_valid,
  input  logic                 con_ready
);

  localparam int CW = $clog2(CON_FIFO_DEPTH) + 1;

  function automatic logic [2:0] sat_cnt(input logic [CW-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    return (w > 32'd7) ? 3'd7 : w[2:0];
  endfunction

  mmio_acc_e        acc;
  logic [CNT_W-1:0] cycle;
  logic [CNT_W-1:0] instret;
  logic [31:0]      cyc_hi_shadow;
  logic [31:0]      ins_hi_shadow;
  logic             freeze;
  logic             overflow;
  logic             wr_lane0;
  logic             cnt_clr;
  logic             frz_wr;
  logic             con_push;
  logic             con_pop;
  logic             ovf_clr;
  logic             rd_cyc_lo;
  logic             rd_ins_lo;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      con_status;
  logic [31:0]      rd_mux_p0;
  logic [31:0]      rdata_p1;

  always_comb begin
    acc = ACC_IDLE;
    if (mmio.mmio_en) acc = (mmio.mmio_we == 4'b0000) ? ACC_READ : ACC_WRITE;
  end

  assign wr_lane0  = (acc == ACC_WRITE) & mmio.mmio_we[0];
  assign cnt_clr   = wr_lane0 & (mmio.mmio_addr == MMIO_CNT_CTRL) & mmio.mmio_wdata[CNT_CTRL_CLR];
  assign frz_wr    = wr_lane0 & (mmio.mmio_addr == MMIO_CNT_CTRL);
  assign con_push  = wr_lane0 & (mmio.mmio_addr == MMIO_CON_TX);
  assign ovf_clr   = wr_lane0 & (mmio.mmio_addr == MMIO_CON_STATUS) & mmio.mmio_wdata[CON_ST_OVF];
  assign con_pop   = con_valid & con_ready;
  assign rd_cyc_lo = (acc == ACC_READ) & (mmio.mmio_addr == MMIO_CYCLE_LO);
  assign rd_ins_lo = (acc == ACC_READ) & (mmio.mmio_addr == MMIO_INSTRET_LO);

  ama_riscv_fifo #(
    .DEPTH (CON_FIFO_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (con_push),
    .push_data (mmio.mmio_wdata[7:0]),
    .pop       (con_pop),
    .pop_data  (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign con_valid = ~fifo_empty;

  always_comb begin
    con_status                        = '0;
    con_status[CON_ST_FULL]           = fifo_full;
    con_status[CON_ST_EMPTY]          = fifo_empty;
    con_status[CON_ST_CNT_LSB +: 3]   = sat_cnt(fifo_count);
    con_status[CON_ST_OVF]            = overflow;
  end

  // Stage p0: read-data select from current register state
  always_comb begin
    rd_mux_p0 = '0;
    case (mmio.mmio_addr)
      MMIO_TOHOST:     rd_mux_p0 = tohost;
      MMIO_CYCLE_LO:   rd_mux_p0 = cycle[31:0];
      MMIO_CYCLE_HI:   rd_mux_p0 = cyc_hi_shadow;
      MMIO_INSTRET_LO: rd_mux_p0 = instret[31:0];
      MMIO_INSTRET_HI: rd_mux_p0 = ins_hi_shadow;
      MMIO_CNT_CTRL:   rd_mux_p0 = {30'b0, freeze, 1'b0};
      MMIO_CON_STATUS: rd_mux_p0 = con_status;
      default:         rd_mux_p0 = '0;
    endcase
  end

  // Stage p1: registered load data, held between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rdata_p1 <= '0;
    else if (acc == ACC_READ)  rdata_p1 <= rd_mux_p0;
  end

  assign mmio.mmio_rdata = rdata_p1;

  // Clear beats increment; the HI shadow latches with the LO read edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle         <= '0;
      instret       <= '0;
      cyc_hi_shadow <= '0;
      ins_hi_shadow <= '0;
      freeze        <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cycle         <= '0;
        instret       <= '0;
        cyc_hi_shadow <= '0;
        ins_hi_shadow <= '0;
      end else begin
        if (!freeze) begin
          cycle <= cycle + CNT_W'(1);
          if (!inst_wb_nop_or_clear) instret <= instret + CNT_W'(1);
        end
        if (rd_cyc_lo) cyc_hi_shadow <= cycle[CNT_W-1:CNT_W-32];
        if (rd_ins_lo) ins_hi_shadow <= instret[CNT_W-1:CNT_W-32];
      end
      if (frz_wr) freeze <= mmio.mmio_wdata[CNT_CTRL_FRZ];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost   <= '0;
      overflow <= 1'b0;
    end else begin
      if ((acc == ACC_WRITE) && (mmio.mmio_addr == MMIO_TOHOST))
        tohost <= merge_lanes(tohost, mmio.mmio_wdata, mmio.mmio_we);
      if (con_push && fifo_full && !con_pop) overflow <= 1'b1;
      else if (ovf_clr)                      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ama_riscv_mmio.sv
// Directed bench for ama_riscv_mmio with read-data and console scoreboards.
module tb_ama_riscv_mmio;
  import ama_riscv_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_wb_nop_or_clear;
  logic [31:0] tohost;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  int tests = 0;
  int fails = 0;

  logic [31:0] rd_q[$];
  string       rd_tag_q[$];
  logic [7:0]  con_q[$];

  ama_riscv_mmio_if bus ();

  ama_riscv_mmio #(
    .CON_FIFO_DEPTH (4),
    .CNT_W          (64)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mmio                 (bus),
    .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
    .tohost               (tohost),
    .con_data             (con_data),
    .con_valid            (con_valid),
    .con_ready            (con_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge; console pops are checked before it, load data after it.
  task automatic step();
    bit rd_pend;
    rd_pend = bus.mmio_en && (bus.mmio_we == 4'b0000) && !rst;
    if (!rst && con_valid && con_ready) begin
      tests++;
      assert (con_q.size() != 0) else begin
        fails++;
        $error("FAIL con_unexpected_pop: got 0x%02h want no data", con_data);
      end
      if (con_q.size() != 0) check("con_data", 32'(con_data), 32'(con_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (rd_pend) check(rd_tag_q.pop_front(), bus.mmio_rdata, rd_q.pop_front());
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    bus.mmio_en   = 1'b1;
    bus.mmio_we   = 4'b0000;
    bus.mmio_addr = a;
    rd_q.push_back(exp);
    rd_tag_q.push_back(tag);
    step();
    bus.mmio_en   = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.mmio_en    = 1'b1;
    bus.mmio_we    = we;
    bus.mmio_addr  = a;
    bus.mmio_wdata = d;
    step();
    bus.mmio_en    = 1'b0;
    bus.mmio_we    = 4'b0000;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.mmio_en          = 1'b0;
    bus.mmio_we          = 4'b0000;
    bus.mmio_addr        = '0;
    bus.mmio_wdata       = '0;
    inst_wb_nop_or_clear = 1'b1;
    con_ready            = 1'b0;
    step();
    step();
    check("rst_tohost", tohost, 32'd0);
    check("rst_rdata", bus.mmio_rdata, 32'd0);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_con_data", 32'(con_data), 32'd0);
    rst = 1'b0;

    // 10 cycles, retiring on every other one
    for (int i = 0; i < 10; i++) begin
      inst_wb_nop_or_clear = (i % 2 == 1);
      step();
    end
    inst_wb_nop_or_clear = 1'b1;
    rd(MMIO_CYCLE_LO, 32'd10, "cycle_lo_after_rst");
    rd(MMIO_INSTRET_LO, 32'd5, "instret_lo_after_rst");
    rd(MMIO_CYCLE_HI, 32'd0, "cycle_hi_after_rst");
    rd(MMIO_CON_STATUS, 32'h0000_0002, "con_status_rst");

    // tohost full-word then single-lane write
    wr(MMIO_TOHOST, 4'b1111, 32'h0000_0001);
    check("tohost_pass", tohost, TOHOST_PASS);
    wr(MMIO_TOHOST, 4'b0010, 32'h0000_AB00);
    check("tohost_lane1", tohost, 32'h0000_AB01);
    rd(MMIO_TOHOST, 32'h0000_AB01, "tohost_read");
    wr(6'h10, 4'b1111, 32'hFFFF_FFFF);
    rd(6'h10, 32'd0, "unmapped_read");
    rd(MMIO_CON_TX, 32'd0, "con_tx_read");

    // LO at 0xFFFF_FFFF, carry into HI must not leak into the HI read
    force dut.cycle = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle;
    rd(MMIO_CYCLE_LO, 32'hFFFF_FFFF, "carry_lo");
    rd(MMIO_CYCLE_HI, 32'd0, "carry_hi_shadow");
    rd(MMIO_CYCLE_LO, 32'd1, "carry_lo2");
    rd(MMIO_CYCLE_HI, 32'd1, "carry_hi_shadow2");

    // clear on a retiring cycle
    inst_wb_nop_or_clear = 1'b0;
    wr(MMIO_CNT_CTRL, 4'b0001, 32'h0000_0001);
    inst_wb_nop_or_clear = 1'b1;
    rd(MMIO_CYCLE_LO, 32'd0, "clr_cycle_lo");
    rd(MMIO_INSTRET_LO, 32'd0, "clr_instret_lo");

    // clear + freeze, then unfreeze
    inst_wb_nop_or_clear = 1'b0;
    wr(MMIO_CNT_CTRL, 4'b0001, 32'h0000_0003);
    step();
    step();
    step();
    rd(MMIO_CYCLE_LO, 32'd0, "frz_cycle_lo");
    rd(MMIO_INSTRET_LO, 32'd0, "frz_instret_lo");
    rd(MMIO_CNT_CTRL, 32'h0000_0002, "frz_ctrl_read");
    wr(MMIO_CNT_CTRL, 4'b0001, 32'h0000_0000);
    rd(MMIO_CYCLE_LO, 32'd0, "unfrz_cycle_lo0");
    rd(MMIO_CYCLE_LO, 32'd1, "unfrz_cycle_lo1");
    rd(MMIO_INSTRET_LO, 32'd2, "unfrz_instret_lo");
    inst_wb_nop_or_clear = 1'b1;

    // overfill the console with the consumer stalled
    for (int b = 'h41; b <= 'h45; b++) begin
      if (b <= 'h44) con_q.push_back(8'(b));
      wr(MMIO_CON_TX, 4'b0001, 32'(b));
    end
    rd(MMIO_CON_STATUS, 32'h0000_0031, "con_status_ovf");
    check("con_valid_full", 32'(con_valid), 32'd1);
    con_ready = 1'b1;
    for (int i = 0; i < 8 && con_valid; i++) step();
    check("con_drained_q", 32'(con_q.size()), 32'd0);
    check("con_valid_empty", 32'(con_valid), 32'd0);
    wr(MMIO_CON_STATUS, 4'b0001, 32'h0000_0020);
    rd(MMIO_CON_STATUS, 32'h0000_0002, "con_status_ovf_clr");

    // full FIFO with simultaneous push and pop
    con_ready = 1'b0;
    for (int b = 'h51; b <= 'h54; b++) begin
      con_q.push_back(8'(b));
      wr(MMIO_CON_TX, 4'b0001, 32'(b));
    end
    rd(MMIO_CON_STATUS, 32'h0000_0011, "con_status_full");
    con_ready = 1'b1;
    con_q.push_back(8'h5A);
    wr(MMIO_CON_TX, 4'b0001, 32'h0000_005A);
    con_ready = 1'b0;
    rd(MMIO_CON_STATUS, 32'h0000_0011, "con_status_pushpop");
    con_ready = 1'b1;
    step();
    step();

    // asynchronous reset in the middle of the drain
    #2;
    rst = 1'b1;
    #1;
    check("midrst_con_valid", 32'(con_valid), 32'd0);
    check("midrst_tohost", tohost, 32'd0);
    check("midrst_rdata", bus.mmio_rdata, 32'd0);
    con_q.delete();
    con_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    rd(MMIO_CYCLE_LO, 32'd0, "midrst_cycle_lo");
    rd(MMIO_CON_STATUS, 32'h0000_0002, "midrst_con_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
